// File: rtl/sha_pkg.sv
// Shared SHA package: block/word types, mode encodings, controller state
// enum, round counts and the message-schedule helper functions.
package sha_pkg;

  localparam int WORD_W      = 64;
  localparam int BLK_W       = 1024;
  localparam int SCHED_DEPTH = 16;

  typedef logic [BLK_W-1:0]  msg_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [2:0]        mode_t;

  // Algorithm encodings; anything above MODE_SHA512 is illegal.
  localparam mode_t MODE_SHA1   = 3'd0;
  localparam mode_t MODE_SHA224 = 3'd1;
  localparam mode_t MODE_SHA256 = 3'd2;
  localparam mode_t MODE_SHA384 = 3'd3;
  localparam mode_t MODE_SHA512 = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_ROUND = 2'd2,
    ST_ADD   = 2'd3
  } ctrl_state_t;

  localparam logic [6:0] ROUNDS_64 = 7'd64;
  localparam logic [6:0] ROUNDS_80 = 7'd80;

  function automatic logic mode_is64(input mode_t m);
    return (m == MODE_SHA384) || (m == MODE_SHA512);
  endfunction

  function automatic logic [6:0] mode_rounds(input mode_t m);
    return ((m == MODE_SHA224) || (m == MODE_SHA256)) ? ROUNDS_64 : ROUNDS_80;
  endfunction

  function automatic logic [31:0] rotl1(input logic [31:0] x);
    return {x[30:0], x[31]};
  endfunction

  // Small sigma-0; 32-bit result is zero-extended.
  function automatic word_t delta0(input word_t x, input logic is64);
    logic [31:0] y;
    y = x[31:0];
    if (is64) begin
      return {x[0], x[63:1]} ^ {x[7:0], x[63:8]} ^ (x >> 7);
    end
    return {32'b0, {y[6:0], y[31:7]} ^ {y[17:0], y[31:18]} ^ (y >> 3)};
  endfunction

  // Small sigma-1; 32-bit result is zero-extended.
  function automatic word_t delta1(input word_t x, input logic is64);
    logic [31:0] y;
    y = x[31:0];
    if (is64) begin
      return {x[18:0], x[63:19]} ^ {x[60:0], x[63:61]} ^ (x >> 6);
    end
    return {32'b0, {y[16:0], y[31:17]} ^ {y[18:0], y[31:19]} ^ (y >> 10)};
  endfunction

endpackage

// File: rtl/sha_msg_sched.sv
// Message schedule: a 16-word window W_t..W_{t+15}. load fills it from the
// block, each shift drops W_t and appends W_{t+16}. w is always W_t.
// SHA-1 expansion is built only when SHA_SHA1_EN is defined.
module sha_msg_sched
  import sha_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  shift,
  input  mode_t mode,
  input  msg_t  blk,
  output word_t w
);

  word_t win [SCHED_DEPTH];
  word_t next_w;
  word_t d0;
  word_t d1;
  word_t sum;
  logic  is64;

`ifdef SHA_SHA1_EN
  logic [31:0] mix1;
`endif

  assign is64 = mode_is64(mode);
  assign w    = win[0];

  // Compute W_{t+16} from the current window (32-bit modes keep words zero-extended).
  always_comb begin
    next_w = '0;
    d0     = delta0(win[1], is64);
    d1     = delta1(win[14], is64);
    sum    = d1 + win[9] + d0 + win[0];
    if (is64) begin
      next_w = sum;
    end else begin
      next_w = {32'b0, sum[31:0]};
    end
`ifdef SHA_SHA1_EN
    mix1 = win[13][31:0] ^ win[8][31:0] ^ win[2][31:0] ^ win[0][31:0];
    if (mode == MODE_SHA1) begin
      next_w = {32'b0, rotl1(mix1)};
    end
`endif
  end

  // Window register: block load or one shift per round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        win[i] <= '0;
      end
    end else if (load) begin
      for (int i = 0; i < SCHED_DEPTH; i++) begin
        win[i] <= is64 ? blk[(15-i)*64 +: 64] : {32'b0, blk[(31-i)*32 +: 32]};
      end
    end else if (shift) begin
      for (int i = 0; i < SCHED_DEPTH-1; i++) begin
        win[i] <= win[i+1];
      end
      win[SCHED_DEPTH-1] <= next_w;
    end
  end

endmodule

// File: rtl/sha_block_ctrl.sv
// SHA block controller: accepts one block, sequences INIT, N rounds and ADD,
// and drives W_t from the schedule sub-module.
// Handshake: a block transfers on a rising edge where blk_valid_i and
// blk_ready_o are both high; blk_ready_o is high only in IDLE.
// Macro SHA_SHA1_EN enables SHA-1; without it a sha1 first block is an error.
module sha_block_ctrl
  import sha_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  mode_t       mode_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  msg_t        blk_i,
  input  logic        blk_first_i,
  input  logic        blk_last_i,
  output logic        init_o,
  output logic        iv_o,
  output logic        rnd_en_o,
  output logic [6:0]  rnd_idx_o,
  output word_t       w_o,
  output logic        add_o,
  output logic        done_o,
  output logic        busy_o,
  output logic        err_o,
  output ctrl_state_t dbg_state
);

  ctrl_state_t state;
  ctrl_state_t state_nxt;
  logic [6:0]  rnd_cnt;
  mode_t       mode_q;
  logic        first_q;
  logic        last_q;
  logic        err_q;
  logic        open_q;
  logic        hs;
  logic        mode_ok;
  logic        blk_err;
  logic        last_round;
  logic        sched_load;
  mode_t       sched_mode;
  word_t       sched_w;

  assign dbg_state  = state;
  assign hs         = blk_valid_i && (state == ST_IDLE);
  assign last_round = (rnd_cnt == (mode_rounds(mode_q) - 7'd1));

  // Legal modes for a first block.
  always_comb begin
`ifdef SHA_SHA1_EN
    mode_ok = (mode_i <= MODE_SHA512);
`else
    mode_ok = (mode_i <= MODE_SHA512) && (mode_i != MODE_SHA1);
`endif
  end

  // A block is dropped if it is an orphan continuation or starts with a bad mode.
  assign blk_err    = blk_first_i ? !mode_ok : !open_q;
  assign sched_load = hs && !blk_err;
  assign sched_mode = ((state == ST_IDLE) && blk_first_i) ? mode_i : mode_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and per-state outputs.
  always_comb begin
    state_nxt   = state;
    blk_ready_o = 1'b0;
    busy_o      = 1'b1;
    init_o      = 1'b0;
    iv_o        = 1'b0;
    rnd_en_o    = 1'b0;
    add_o       = 1'b0;
    done_o      = 1'b0;
    err_o       = 1'b0;
    case (state)
      ST_IDLE: begin
        blk_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (blk_valid_i) state_nxt = ST_INIT;
      end
      ST_INIT: begin
        err_o     = err_q;
        init_o    = !err_q;
        iv_o      = first_q && !err_q;
        state_nxt = err_q ? ST_IDLE : ST_ROUND;
      end
      ST_ROUND: begin
        rnd_en_o = 1'b1;
        if (last_round) state_nxt = ST_ADD;
      end
      ST_ADD: begin
        add_o     = 1'b1;
        done_o    = last_q;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Round counter runs only in ROUND and parks at zero elsewhere.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_cnt <= '0;
    end else if ((state == ST_ROUND) && !last_round) begin
      rnd_cnt <= rnd_cnt + 7'd1;
    end else begin
      rnd_cnt <= '0;
    end
  end

  // Block flags, message mode and open-message tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= MODE_SHA1;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      open_q  <= 1'b0;
    end else if (hs) begin
      first_q <= blk_first_i;
      last_q  <= blk_last_i;
      err_q   <= blk_err;
      if (blk_first_i && mode_ok) begin
        mode_q <= mode_i;
        open_q <= 1'b1;
      end
    end else if ((state == ST_ADD) && last_q) begin
      open_q <= 1'b0;
    end
  end

  assign rnd_idx_o = rnd_en_o ? rnd_cnt : 7'd0;
  assign w_o       = rnd_en_o ? sched_w : '0;

  sha_msg_sched u_sched (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (sched_load),
    .shift (rnd_en_o),
    .mode  (sched_mode),
    .blk   (blk_i),
    .w     (sched_w)
  );

endmodule

// File: tb/tb_sha_block_ctrl.sv
// Bench for sha_block_ctrl: directed block sequence, reference W-schedule
// model feeding an expected queue, timing/flag checks per block.
module tb_sha_block_ctrl;
  import sha_pkg::*;

  localparam int EXP_W = 71;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  mode_t       mode_i = '0;
  logic        blk_valid_i = 1'b0;
  logic        blk_ready_o;
  msg_t        blk_i = '0;
  logic        blk_first_i = 1'b0;
  logic        blk_last_i = 1'b0;
  logic        init_o, iv_o, rnd_en_o;
  logic [6:0]  rnd_idx_o;
  word_t       w_o;
  logic        add_o, done_o, busy_o, err_o;
  ctrl_state_t dbg_state;

  int n_checks = 0;
  int n_pass = 0;
  int n_fail = 0;
  int add_count = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [63:0] mon_w16 = '0;
  logic [63:0] mon_w17 = '0;
  logic [6:0]  mon_max_idx = '0;

  sha_block_ctrl dut (
    .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o), .blk_i(blk_i),
    .blk_first_i(blk_first_i), .blk_last_i(blk_last_i),
    .init_o(init_o), .iv_o(iv_o), .rnd_en_o(rnd_en_o), .rnd_idx_o(rnd_idx_o),
    .w_o(w_o), .add_o(add_o), .done_o(done_o), .busy_o(busy_o), .err_o(err_o),
    .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic checkw(input string tag, input logic [EXP_W-1:0] obs, input logic [EXP_W-1:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checkw(tag, EXP_W'(obs), EXP_W'(exp));
  endtask

  function automatic logic [31:0] rotr32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction
  function automatic logic [31:0] ss0_32(input logic [31:0] x);
    return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1_32(input logic [31:0] x);
    return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
  endfunction
  function automatic logic [63:0] ss0_64(input logic [63:0] x);
    return rotr64(x, 1) ^ rotr64(x, 8) ^ (x >> 7);
  endfunction
  function automatic logic [63:0] ss1_64(input logic [63:0] x);
    return rotr64(x, 19) ^ rotr64(x, 61) ^ (x >> 6);
  endfunction
  function automatic logic is64b(input mode_t m);
    return (m == MODE_SHA384) || (m == MODE_SHA512);
  endfunction
  function automatic int bench_rounds(input mode_t m);
    return ((m == MODE_SHA224) || (m == MODE_SHA256)) ? 64 : 80;
  endfunction
  function automatic msg_t rand_blk();
    msg_t b;
    for (int i = 0; i < 32; i++) b[i*32 +: 32] = $urandom();
    return b;
  endfunction

  // Reference schedule computed over a full 80-word array.
  task automatic push_model(input mode_t m, input msg_t blk);
    logic [63:0] w [80];
    logic [31:0] x;
    int n;
    n = bench_rounds(m);
    for (int t = 0; t < 80; t++) begin
      if (t < 16) begin
        if (is64b(m)) w[t] = blk[(15-t)*64 +: 64];
        else          w[t] = {32'b0, blk[(31-t)*32 +: 32]};
      end else if (m == MODE_SHA1) begin
        x = w[t-3][31:0] ^ w[t-8][31:0] ^ w[t-14][31:0] ^ w[t-16][31:0];
        w[t] = {32'b0, x[30:0], x[31]};
      end else if (is64b(m)) begin
        w[t] = ss1_64(w[t-2]) + w[t-7] + ss0_64(w[t-15]) + w[t-16];
      end else begin
        x = ss1_32(w[t-2][31:0]) + w[t-7][31:0] + ss0_32(w[t-15][31:0]) + w[t-16][31:0];
        w[t] = {32'b0, x};
      end
    end
    for (int t = 0; t < n; t++) exp_q.push_back({7'(t), w[t]});
  endtask

  // Scoreboard: every round beat is popped against the model.
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (rst_n) begin
      if (add_o) add_count++;
      if (rnd_en_o) begin
        if (rnd_idx_o == 7'd16) mon_w16 = w_o;
        if (rnd_idx_o == 7'd17) mon_w17 = w_o;
        if (rnd_idx_o > mon_max_idx) mon_max_idx = rnd_idx_o;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $error("FAIL round_extra: observed idx %0d w %h expected no round", rnd_idx_o, w_o);
        end else begin
          e = exp_q.pop_front();
          checkw("round_w", {rnd_idx_o, w_o}, e);
        end
      end
    end
  end

  task automatic reset_checks();
    rst_n = 1'b0;
    blk_valid_i = 1'b0; blk_first_i = 1'b0; blk_last_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_ready", blk_ready_o, 1'b1);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_init", init_o, 1'b0);
    check1("rst_iv", iv_o, 1'b0);
    check1("rst_rnd_en", rnd_en_o, 1'b0);
    checkw("rst_idx", EXP_W'(rnd_idx_o), '0);
    checkw("rst_w", EXP_W'(w_o), '0);
    check1("rst_add", add_o, 1'b0);
    check1("rst_done", done_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    checkw("rst_state", EXP_W'(dbg_state), EXP_W'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drive one block and check its full timeline; returns in IDLE.
  task automatic run_block(input string tag, input mode_t drv_mode, input mode_t eff_mode,
                           input msg_t blk, input logic first, input logic last, input logic exp_err);
    int n;
    logic ready_hi, err_hi, add_early, rnd_gap;
    n = bench_rounds(eff_mode);
    if (!exp_err) push_model(eff_mode, blk);
    mon_max_idx = '0; mon_w16 = '0; mon_w17 = '0;
    @(negedge clk);
    check1({tag, "_ready_idle"}, blk_ready_o, 1'b1);
    mode_i = drv_mode; blk_i = blk; blk_first_i = first; blk_last_i = last; blk_valid_i = 1'b1;
    @(posedge clk); #1;
    blk_valid_i = 1'b0; blk_first_i = 1'b0; blk_last_i = 1'b0;
    mode_i = 3'($urandom_range(0, 7));
    if (exp_err) begin
      check1({tag, "_err_pulse"}, err_o, 1'b1);
      check1({tag, "_err_noinit"}, init_o, 1'b0);
      check1({tag, "_err_nornd"}, rnd_en_o, 1'b0);
      @(posedge clk); #1;
      checkw({tag, "_err_idle"}, EXP_W'(dbg_state), EXP_W'(ST_IDLE));
      check1({tag, "_err_clear"}, err_o, 1'b0);
      check1({tag, "_err_nornd2"}, rnd_en_o, 1'b0);
    end else begin
      check1({tag, "_init"}, init_o, 1'b1);
      check1({tag, "_iv"}, iv_o, first);
      check1({tag, "_noerr"}, err_o, 1'b0);
      ready_hi = blk_ready_o; err_hi = 1'b0; add_early = 1'b0; rnd_gap = 1'b0;
      repeat (n) begin
        @(posedge clk); #1;
        ready_hi |= blk_ready_o; err_hi |= err_o; add_early |= add_o; rnd_gap |= !rnd_en_o;
      end
      check1({tag, "_ready_low"}, ready_hi, 1'b0);
      check1({tag, "_no_err_rounds"}, err_hi, 1'b0);
      check1({tag, "_no_early_add"}, add_early, 1'b0);
      check1({tag, "_rounds_contig"}, rnd_gap, 1'b0);
      @(posedge clk); #1;
      check1({tag, "_add"}, add_o, 1'b1);
      check1({tag, "_done"}, done_o, last);
      check1({tag, "_add_ready_low"}, blk_ready_o, 1'b0);
      @(posedge clk); #1;
      check1({tag, "_back_ready"}, blk_ready_o, 1'b1);
      checkw({tag, "_back_idle"}, EXP_W'(dbg_state), EXP_W'(ST_IDLE));
      check1({tag, "_add_clear"}, add_o, 1'b0);
    end
  endtask

  initial begin
    msg_t abc;
    msg_t b1;
    int add_base;
    abc = '0;
    abc[1023:992] = 32'h61626380;
    abc[543:512]  = 32'h00000018;

    reset_checks();

    // SHA-256 "abc"
    run_block("abc256", MODE_SHA256, MODE_SHA256, abc, 1'b1, 1'b1, 1'b0);
    checkw("abc256_w16", EXP_W'(mon_w16), EXP_W'(64'h61626380));
    checkw("abc256_w17", EXP_W'(mon_w17), EXP_W'(64'h000F0000));
    checkw("abc256_maxidx", EXP_W'(mon_max_idx), EXP_W'(7'd63));

    // SHA-1 "abc"
`ifdef SHA_SHA1_EN
    run_block("abc1", MODE_SHA1, MODE_SHA1, abc, 1'b1, 1'b1, 1'b0);
    checkw("abc1_w16", EXP_W'(mon_w16), EXP_W'(64'hC2C4C700));
    checkw("abc1_maxidx", EXP_W'(mon_max_idx), EXP_W'(7'd79));
`else
    run_block("sha1_off", MODE_SHA1, MODE_SHA1, abc, 1'b1, 1'b1, 1'b1);
`endif

    // SHA-512 two-block message
    run_block("s512_b0", MODE_SHA512, MODE_SHA512, rand_blk(), 1'b1, 1'b0, 1'b0);
    checkw("s512_maxidx", EXP_W'(mon_max_idx), EXP_W'(7'd79));
    run_block("s512_b1", MODE_SHA512, MODE_SHA512, rand_blk(), 1'b0, 1'b1, 1'b0);

    // Other modes, single block
    run_block("s224", MODE_SHA224, MODE_SHA224, rand_blk(), 1'b1, 1'b1, 1'b0);
    run_block("s384", MODE_SHA384, MODE_SHA384, rand_blk(), 1'b1, 1'b1, 1'b0);

    // Protocol errors
    run_block("orphan", MODE_SHA256, MODE_SHA256, rand_blk(), 1'b0, 1'b1, 1'b1);
    run_block("bad_mode", 3'd6, 3'd6, rand_blk(), 1'b1, 1'b1, 1'b1);
    run_block("bad_mode7", 3'd7, 3'd7, rand_blk(), 1'b1, 1'b0, 1'b1);
    run_block("orphan2", MODE_SHA256, MODE_SHA256, rand_blk(), 1'b0, 1'b0, 1'b1);

    // Mode on a continuation block is ignored
    run_block("cont_b0", MODE_SHA256, MODE_SHA256, rand_blk(), 1'b1, 1'b0, 1'b0);
    run_block("cont_b1", MODE_SHA512, MODE_SHA256, rand_blk(), 1'b0, 1'b1, 1'b0);

    // First block while a message is open restarts with the new mode
    run_block("rst_b0", MODE_SHA256, MODE_SHA256, rand_blk(), 1'b1, 1'b0, 1'b0);
    run_block("restart", MODE_SHA384, MODE_SHA384, rand_blk(), 1'b1, 1'b1, 1'b0);

    // Reset at round 30
    b1 = rand_blk();
    push_model(MODE_SHA256, b1);
    add_base = add_count;
    @(negedge clk);
    mode_i = MODE_SHA256; blk_i = b1; blk_first_i = 1'b1; blk_last_i = 1'b0; blk_valid_i = 1'b1;
    @(posedge clk); #1;
    blk_valid_i = 1'b0; blk_first_i = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    checkw("abort_at_r30", EXP_W'(rnd_idx_o), EXP_W'(7'd30));
    rst_n = 1'b0;
    #1;
    check1("abort_rnd_en", rnd_en_o, 1'b0);
    check1("abort_ready", blk_ready_o, 1'b1);
    check1("abort_busy", busy_o, 1'b0);
    checkw("abort_w", EXP_W'(w_o), '0);
    checkw("abort_idx", EXP_W'(rnd_idx_o), '0);
    check1("abort_add", add_o, 1'b0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkw("abort_no_add", EXP_W'(add_count), EXP_W'(add_base));
    run_block("post_rst_orphan", MODE_SHA256, MODE_SHA256, rand_blk(), 1'b0, 1'b1, 1'b1);
    run_block("post_rst", MODE_SHA256, MODE_SHA256, abc, 1'b1, 1'b1, 1'b0);
    checkw("post_rst_w16", EXP_W'(mon_w16), EXP_W'(64'h61626380));

    repeat (2) @(posedge clk);
    #1;
    checkw("exp_q_drained", EXP_W'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
